sha256_msg_padder: RTL

Upstream feeder for the SHA-256 hash core. On `start` it reads a message of `msg_words` 32-bit words from memory and streams it out one word at a time over a valid/ready handshake, appending standard SHA-256 padding (0x80000000 marker word, zero fill, 64-bit bit-length) so the core receives complete 16-word blocks. Block and message boundaries are flagged on the output.

---
 rtl/sha256_msg_padder_if.sv | 24 ++
 rtl/sha256_msg_padder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder_if.sv
// Word stream from the SHA-256 message padder to the hash core.
interface sha256_msg_padder_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_block_last;
  logic        out_msg_last;

  modport master (
    output out_valid,
    output out_word,
    output out_block_last,
    output out_msg_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_word,
    input  out_block_last,
    input  out_msg_last,
    output out_ready
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Reads a message from word memory and streams it with SHA-256 padding in 16-word blocks.
// Optional SHA_PAD_BSWAP_EN byte-reverses memory words for little-endian message storage.
module sha256_msg_padder #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          msg_addr,
  input  logic [15:0]                msg_words,
  output logic                       mem_clk,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [31:0]                mem_read_data,
  output logic                       busy,
  output logic                       done,
  sha256_msg_padder_if.master        stream
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned IDX_W  = 17;
  localparam logic [WORD_W-1:0] PAD_MARK = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    n_words;
  logic [IDX_W-1:0]    total;
  logic [IDX_W-1:0]    idx;

  logic [IDX_W-1:0]    total_c;
  logic [IDX_W-1:0]    last_idx_c;
  logic [IDX_W-1:0]    idx_nxt_c;
  logic [WORD_W-1:0]   pad_word_c;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  function automatic logic [WORD_W-1:0] mem_to_stream(input logic [WORD_W-1:0] w);
`ifdef SHA_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Round (msg_words + marker + two length words) up to whole 16-word blocks.
  assign total_c    = (IDX_W'(msg_words) + IDX_W'(18)) & ~IDX_W'(15);
  assign last_idx_c = total - IDX_W'(1);
  assign idx_nxt_c  = idx + IDX_W'(1);

  // Padding content for the word after the current one; only used past the message body.
  always_comb begin
    pad_word_c = '0;
    if (idx_nxt_c == IDX_W'(n_words)) begin
      pad_word_c = PAD_MARK;
    end else if (idx_nxt_c == last_idx_c) begin
      pad_word_c = WORD_W'({n_words, 5'b0});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                 <= S_IDLE;
      base_addr             <= '0;
      n_words               <= '0;
      total                 <= '0;
      idx                   <= '0;
      mem_addr              <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      stream.out_valid      <= 1'b0;
      stream.out_word       <= '0;
      stream.out_block_last <= 1'b0;
      stream.out_msg_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_addr <= msg_addr;
            n_words   <= msg_words;
            total     <= total_c;
            idx       <= '0;
            busy      <= 1'b1;
            if (msg_words != '0) begin
              mem_addr <= msg_addr;
              state    <= S_FETCH;
            end else begin
              stream.out_word  <= PAD_MARK;
              stream.out_valid <= 1'b1;
              state            <= S_EMIT;
            end
          end
        end

        // Address is already on mem_addr; the read data lands during WAIT.
        S_FETCH: state <= S_WAIT;

        S_WAIT: begin
          stream.out_word       <= mem_to_stream(mem_read_data);
          stream.out_valid      <= 1'b1;
          stream.out_block_last <= (idx[3:0] == 4'hF);
          stream.out_msg_last   <= (idx == last_idx_c);
          state                 <= S_EMIT;
        end

        S_EMIT: begin
          if (stream.out_ready) begin
            idx <= idx_nxt_c;
            if (idx == last_idx_c) begin
              stream.out_valid      <= 1'b0;
              stream.out_block_last <= 1'b0;
              stream.out_msg_last   <= 1'b0;
              busy                  <= 1'b0;
              done                  <= 1'b1;
              state                 <= S_IDLE;
            end else if (idx_nxt_c < IDX_W'(n_words)) begin
              stream.out_valid      <= 1'b0;
              stream.out_block_last <= 1'b0;
              stream.out_msg_last   <= 1'b0;
              mem_addr              <= base_addr + ADDR_W'(idx_nxt_c);
              state                 <= S_FETCH;
            end else begin
              stream.out_word       <= pad_word_c;
              stream.out_block_last <= (idx_nxt_c[3:0] == 4'hF);
              stream.out_msg_last   <= (idx_nxt_c == last_idx_c);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
